// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common-data-bus arbiter: requester identities and
// the default requester count and ROB depth used by the CDB datapath.
package cdb_arbiter_pkg;

  localparam int NUM_REQ_DEFAULT  = 4;
  localparam int ROB_SIZE_DEFAULT = 8;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MUL  = 2'd1,
    FU_DIV  = 2'd2,
    FU_LOAD = 2'd3
  } fu_e;

  // Index width that stays legal for a single-entry vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin winner select: scans from ptr upward, wrapping,
// and returns the first valid requester as a one-hot vector plus its index.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int N   = NUM_REQ_DEFAULT,
  localparam int IXW = clog2_min1(N)
) (
  input  logic [N-1:0]   valid,
  input  logic [IXW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IXW-1:0] grant_ix,
  output logic           any
);

  always_comb begin
    logic [IXW-1:0] idx;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned; otherwise synthesis infers a latch.
    grant    = '0;
    grant_ix = '0;
    any      = 1'b0;
    idx      = ptr;
    for (int off = 0; off < N; off++) begin
      if (!any && valid[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_ix   = idx;
      end
      idx = (idx == IXW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one functional-unit result per cycle in
// round-robin order and broadcasts it on the CDB one cycle later.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int NUM_REQ  = NUM_REQ_DEFAULT,
  parameter  int ROB_SIZE = ROB_SIZE_DEFAULT,
  localparam int PTR_SIZE = $clog2(ROB_SIZE),
  localparam int SRC_W    = clog2_min1(NUM_REQ)
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               flush_in,
  input  logic [NUM_REQ-1:0]                 req_valid_in,
  input  logic [NUM_REQ-1:0][PTR_SIZE-1:0]   req_rob_ix_in,
  input  logic [NUM_REQ-1:0][31:0]           req_value_in,
  input  logic [NUM_REQ-1:0][31:0]           req_dest_in,
  output logic [NUM_REQ-1:0]                 req_ready_out,
  output logic                               cdb_valid_out,
  output logic [PTR_SIZE-1:0]                cdb_rob_ix_out,
  output logic signed [31:0]                 cdb_value_out,
  output logic signed [31:0]                 cdb_dest_out,
  output logic [SRC_W-1:0]                   cdb_src_out
);

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   rr_ptr_next;
  logic [NUM_REQ-1:0] win;
  logic [SRC_W-1:0]   win_ix;
  logic               win_any;
  logic               grant_any;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .valid    (req_valid_in),
    .ptr      (rr_ptr),
    .grant    (win),
    .grant_ix (win_ix),
    .any      (win_any)
  );

  // Reset gates the grant too, so nothing is accepted while it is held.
  assign grant_any     = win_any && !flush_in && !rst_in;
  assign req_ready_out = grant_any ? win : '0;
  assign rr_ptr_next   = (win_ix == SRC_W'(NUM_REQ - 1)) ? '0 : win_ix + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr         <= '0;
      cdb_valid_out  <= 1'b0;
      cdb_rob_ix_out <= '0;
      cdb_value_out  <= '0;
      cdb_dest_out   <= '0;
      cdb_src_out    <= '0;
    end else begin
      cdb_valid_out <= grant_any;
      // Payload holds its last value on idle cycles; only valid drops.
      if (grant_any) begin
        rr_ptr         <= rr_ptr_next;
        cdb_rob_ix_out <= req_rob_ix_in[win_ix];
        cdb_value_out  <= req_value_in[win_ix];
        cdb_dest_out   <= req_dest_in[win_ix];
        cdb_src_out    <= win_ix;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued when a grant
// is expected and compared when the CDB register updates.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int PW = 3;

  typedef struct packed {
    logic        valid;
    logic [2:0]  rob;
    logic [31:0] value;
    logic [31:0] dest;
    logic [1:0]  src;
  } sb_item_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic [N-1:0]         valid;
  logic [N-1:0][PW-1:0] rob;
  logic [N-1:0][31:0]   value;
  logic [N-1:0][31:0]   dest;
  logic [N-1:0]         ready;
  logic                 cdb_valid;
  logic [PW-1:0]        cdb_rob;
  logic signed [31:0]   cdb_value;
  logic signed [31:0]   cdb_dest;
  logic [1:0]           cdb_src;

  sb_item_t sb[$];
  sb_item_t last;
  int       n_cmp  = 0;
  int       n_fail = 0;

  cdb_arbiter dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .flush_in       (flush),
    .req_valid_in   (valid),
    .req_rob_ix_in  (rob),
    .req_value_in   (value),
    .req_dest_in    (dest),
    .req_ready_out  (ready),
    .cdb_valid_out  (cdb_valid),
    .cdb_rob_ix_out (cdb_rob),
    .cdb_value_out  (cdb_value),
    .cdb_dest_out   (cdb_dest),
    .cdb_src_out    (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cdb_zero(input string tag);
    check({tag, ".cdb_valid"}, 32'(cdb_valid), 32'd0);
    check({tag, ".cdb_rob"},   32'(cdb_rob),   32'd0);
    check({tag, ".cdb_value"}, cdb_value,      32'd0);
    check({tag, ".cdb_dest"},  cdb_dest,       32'd0);
    check({tag, ".cdb_src"},   32'(cdb_src),   32'd0);
  endtask

  // Called at posedge+1 with inputs already driven. Checks the grant at the
  // negedge, queues the expected broadcast, then checks it after the edge.
  task automatic cycle(input logic [N-1:0] exp_ready, input string tag);
    sb_item_t it;
    sb_item_t got;
    @(negedge clk);
    check({tag, ".ready"}, 32'(ready), 32'(exp_ready));
    it = last;
    it.valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (exp_ready[i]) begin
        it = '{valid: 1'b1, rob: rob[i], value: value[i], dest: dest[i], src: 2'(i)};
        last = it;
      end
    end
    sb.push_back(it);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, ".cdb_valid"}, 32'(cdb_valid), 32'(got.valid));
    check({tag, ".cdb_rob"},   32'(cdb_rob),   32'(got.rob));
    check({tag, ".cdb_value"}, cdb_value,      got.value);
    check({tag, ".cdb_dest"},  cdb_dest,       got.dest);
    check({tag, ".cdb_src"},   32'(cdb_src),   32'(got.src));
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    valid = '0;
    rob   = '0;
    value = '0;
    dest  = '0;
    last  = '0;

    // Reset holds everything at zero even with all requesters valid.
    #2;
    valid = 4'b1111;
    check_cdb_zero("reset");
    @(negedge clk);
    check("reset.ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    check("reset.hold_valid", 32'(cdb_valid), 32'd0);
    valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset.cdb_valid", 32'(cdb_valid), 32'd0);

    // Single request from MUL.
    valid = 4'b0010;
    rob[int'(FU_MUL)]   = 3'd5;
    value[int'(FU_MUL)] = 32'd42;
    dest[int'(FU_MUL)]  = 32'd100;
    cycle(4'b0010, "single");
    valid = '0;
    cycle(4'b0000, "idle_hold");

    // Store result from LOAD with negative offset.
    valid = 4'b1000;
    rob[int'(FU_LOAD)]   = 3'd7;
    value[int'(FU_LOAD)] = 32'h0000_1234;
    dest[int'(FU_LOAD)]  = -32'sd8;
    cycle(4'b1000, "store");
    check("store.sign", cdb_dest, 32'hFFFF_FFF8);

    // All valid for 8 cycles; requesters 0 and 1 share a ROB index.
    valid = 4'b1111;
    rob   = {3'd3, 3'd2, 3'd4, 3'd4};
    for (int i = 0; i < N; i++) begin
      value[i] = 32'd1000 + 32'(i);
      dest[i]  = 32'(i * 4);
    end
    for (int k = 0; k < 8; k++) cycle(N'(1) << (k % N), "fair");

    // Move pointer to 3, then exercise the wrap 3 -> 0.
    valid = 4'b0100;
    cycle(4'b0100, "wrap_setup");
    valid = 4'b1001;
    cycle(4'b1000, "wrap_hi");
    cycle(4'b0001, "wrap_lo");

    // Flush blocks the grant; the held request wins the next cycle.
    valid = 4'b0100;
    flush = 1'b1;
    cycle(4'b0000, "flush");
    flush = 1'b0;
    cycle(4'b0100, "after_flush");

    // Asynchronous reset in the middle of a broadcast cycle.
    valid = 4'b0010;
    rob[1]   = 3'd6;
    value[1] = 32'd77;
    cycle(4'b0010, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    check_cdb_zero("mid_reset");
    check("mid_reset.ready", 32'(ready), 32'd0);
    valid = '0;
    #2;
    rst = 1'b0;
    sb.delete();
    last = '0;
    @(posedge clk);
    #1;
    check("mid_reset.no_replay", 32'(cdb_valid), 32'd0);

    // Pointer back at 0: requester 0 wins over 1..3.
    valid = 4'b1111;
    cycle(4'b0001, "ptr_reset");
    valid = '0;
    cycle(4'b0000, "final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
